// File: rtl/writeback_stage.sv
// Writeback stage: registers the M-stage bundle and selects the register-file
// result, formatting loads by size, sign and byte offset.
module writeback_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ALUResult_M,
  input  logic [XLEN-1:0] ReadData_M,
  input  logic [XLEN-1:0] PCPlus4_M,
  input  logic [1:0]      ResultSrc_M,
  input  logic [2:0]      Funct3_M,
  input  logic            RegWrite_M,
  input  logic [4:0]      Rd_M,
  output logic [XLEN-1:0] Result_W,
  output logic            RegWrite_W,
  output logic [4:0]      Rd_W
);

  logic [XLEN-1:0] ALUResult_W;
  logic [XLEN-1:0] ReadData_W;
  logic [XLEN-1:0] PCPlus4_W;
  logic [1:0]      ResultSrc_W;
  logic [2:0]      Funct3_W;
  logic            RegWrite_W_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult_W  <= '0;
      ReadData_W   <= '0;
      PCPlus4_W    <= '0;
      ResultSrc_W  <= '0;
      Funct3_W     <= '0;
      RegWrite_W_q <= 1'b0;
      Rd_W         <= '0;
    end else begin
      ALUResult_W  <= ALUResult_M;
      ReadData_W   <= ReadData_M;
      PCPlus4_W    <= PCPlus4_M;
      ResultSrc_W  <= ResultSrc_M;
      Funct3_W     <= Funct3_M;
      RegWrite_W_q <= RegWrite_M;
      Rd_W         <= Rd_M;
    end
  end

  logic [2:0]      off;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [31:0]     lane_w;
  logic [XLEN-1:0] LoadData_W;

  assign off = ALUResult_W[2:0];

  // Low address bits below the access size are dropped, not trapped
  always_comb begin
    lane_b = ReadData_W[{off, 3'b000} +: 8];
    lane_h = ReadData_W[{off[2:1], 4'b0000} +: 16];
    lane_w = ReadData_W[{off[2], 5'b00000} +: 32];
    LoadData_W = ReadData_W;
    unique case (Funct3_W)
      3'b000: LoadData_W = {{(XLEN-8){lane_b[7]}}, lane_b};
      3'b001: LoadData_W = {{(XLEN-16){lane_h[15]}}, lane_h};
      3'b010: LoadData_W = {{(XLEN-32){lane_w[31]}}, lane_w};
      3'b100: LoadData_W = {{(XLEN-8){1'b0}}, lane_b};
      3'b101: LoadData_W = {{(XLEN-16){1'b0}}, lane_h};
      3'b110: LoadData_W = {{(XLEN-32){1'b0}}, lane_w};
      default: LoadData_W = ReadData_W;
    endcase
  end

  always_comb begin
    Result_W = '0;
    unique case (1'b1)
      ResultSrc_W == 2'b00: Result_W = ALUResult_W;
      ResultSrc_W == 2'b01: Result_W = LoadData_W;
      ResultSrc_W == 2'b10: Result_W = PCPlus4_W;
      ResultSrc_W == 2'b11: Result_W = '0;
    endcase
  end

  assign RegWrite_W = RegWrite_W_q && (Rd_W != 5'd0);

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors, random traffic
// and asynchronous reset pulses checked against a load-format model.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] ALUResult_M;
  logic [63:0] ReadData_M;
  logic [63:0] PCPlus4_M;
  logic [1:0]  ResultSrc_M;
  logic [2:0]  Funct3_M;
  logic        RegWrite_M;
  logic [4:0]  Rd_M;
  logic [63:0] Result_W;
  logic        RegWrite_W;
  logic [4:0]  Rd_W;

  writeback_stage #(.XLEN(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ALUResult_M(ALUResult_M),
    .ReadData_M(ReadData_M),
    .PCPlus4_M(PCPlus4_M),
    .ResultSrc_M(ResultSrc_M),
    .Funct3_M(Funct3_M),
    .RegWrite_M(RegWrite_M),
    .Rd_M(Rd_M),
    .Result_W(Result_W),
    .RegWrite_W(RegWrite_W),
    .Rd_W(Rd_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        we;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Loads as: pick size, round address down to size, shift, mask, extend
  function automatic logic [63:0] model(logic [63:0] alu, logic [63:0] rdat,
                                        logic [63:0] pc, logic [1:0] src,
                                        logic [2:0] f3);
    int nb;
    int aoff;
    logic [63:0] v;
    logic [63:0] mask;
    case (src)
      2'd0: return alu;
      2'd2: return pc;
      2'd3: return 64'h0;
      default: ;
    endcase
    nb = 1 << f3[1:0];
    aoff = (int'(alu[2:0]) / nb) * nb;
    v = rdat >> (8 * aoff);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic drive(logic [63:0] alu, logic [63:0] rdat, logic [63:0] pc,
                       logic [1:0] src, logic [2:0] f3, logic we,
                       logic [4:0] rd);
    exp_t e;
    ALUResult_M = alu;
    ReadData_M  = rdat;
    PCPlus4_M   = pc;
    ResultSrc_M = src;
    Funct3_M    = f3;
    RegWrite_M  = we;
    Rd_M        = rd;
    e.res = model(alu, rdat, pc, src, f3);
    e.we  = we && (rd != 5'd0);
    e.rd  = rd;
    q.push_back(e);
  endtask

  task automatic drive_rand();
    logic [4:0] rd;
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    drive({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          2'($urandom), 3'($urandom), 1'($urandom), rd);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && rst_n && q.size() != 0) begin
      e = q.pop_front();
      check("result", Result_W, e.res);
      check("regwrite", {63'd0, RegWrite_W}, {63'd0, e.we});
      check("rd", {59'd0, Rd_W}, {59'd0, e.rd});
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_result"}, Result_W, 64'h0);
    check({tag, "_regwrite"}, {63'd0, RegWrite_W}, 64'h0);
    check({tag, "_rd"}, {59'd0, Rd_W}, 64'h0);
  endtask

  localparam logic [63:0] RD2 = 64'h8877_6655_4433_2211;

  initial begin
    rst_n = 1'b1;
    ALUResult_M = 64'h1234;
    ReadData_M  = 64'h5678;
    PCPlus4_M   = 64'h9abc;
    ResultSrc_M = 2'd0;
    Funct3_M    = 3'd0;
    RegWrite_M  = 1'b1;
    Rd_M        = 5'd3;
    #2 rst_n = 1'b0;
    #1 check_zero("por");
    @(posedge clk) #1 check_zero("por_hold");
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'h1004,
          2'd0, 3'b011, 1'b1, 5'd5);
    for (int s = 1; s < 4; s++) begin
      @(negedge clk);
      drive(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'h1004,
            2'(s), 3'b011, 1'b1, 5'd5);
    end
    @(negedge clk) drive(64'h1007, RD2, 64'h0, 2'd1, 3'b000, 1'b1, 5'd1);
    @(negedge clk) drive(64'h1007, RD2, 64'h0, 2'd1, 3'b100, 1'b1, 5'd2);
    @(negedge clk) drive(64'h1002, RD2, 64'h0, 2'd1, 3'b001, 1'b1, 5'd3);
    @(negedge clk) drive(64'h1004, RD2, 64'h0, 2'd1, 3'b110, 1'b1, 5'd4);
    @(negedge clk) drive(64'h1004, RD2, 64'h0, 2'd1, 3'b010, 1'b1, 5'd6);
    @(negedge clk) drive(64'h1003, RD2, 64'h0, 2'd1, 3'b111, 1'b1, 5'd7);
    @(negedge clk) drive(64'h1003, RD2, 64'h0, 2'd1, 3'b011, 1'b1, 5'd8);
    @(negedge clk) drive(64'h1005, RD2, 64'h0, 2'd1, 3'b001, 1'b1, 5'd9);
    @(negedge clk) drive(64'h1006, RD2, 64'h0, 2'd1, 3'b010, 1'b1, 5'd9);
    @(negedge clk) drive(64'h55, RD2, 64'h77, 2'd0, 3'b000, 1'b1, 5'd0);
    @(negedge clk) drive(64'h55, RD2, 64'h77, 2'd2, 3'b101, 1'b0, 5'd31);
    repeat (200) begin
      @(negedge clk) drive_rand();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(64'hDEAD_0000 + 64'(k), RD2, 64'h2000, 2'd0, 3'b011, 1'b1, 5'd9);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1 check_zero("rst_pulse");
      q.delete();
      @(posedge clk) #1 check_zero("rst_edge");
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;
      drive(64'h0, RD2, 64'h3000 + 64'(k), 2'd2, 3'b000, 1'b1, 5'd7);
      #1 check_zero("rst_release");
      repeat (20) begin
        @(negedge clk) drive_rand();
      end
    end
    @(posedge clk);
    #3;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width; all behaviour below is defined for XLEN=64.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ALUResult_M  input  64  execute result; also the load address.
REQ-006 ReadData_M  input  64  aligned doubleword read from data memory.
REQ-007 PCPlus4_M  input  64  link address for JAL/JALR.
REQ-008 ResultSrc_M  input  2  result select.
REQ-009 Funct3_M  input  3  load size/sign code.
REQ-010 RegWrite_M  input  1  register-file write request.
REQ-011 Rd_M  input  5  destination register.
REQ-012 Result_W  output  64  value written to the register file and forwarded.
REQ-013 RegWrite_W  output  1  register-file write enable.
REQ-014 Rd_W  output  5  destination register.

Function
REQ-015 On every rising clk edge with rst_n high, the block SHALL capture all *_M inputs into internal W-stage registers: ALUResult_W, ReadData_W, PCPlus4_W, ResultSrc_W, Funct3_W, RegWrite_W_q, Rd_W.
REQ-016 Outputs SHALL be combinational functions of the W-stage registers only, giving one cycle of latency from the M inputs.
REQ-017 ResultSrc_W=00 SHALL select ALUResult_W.
REQ-018 ResultSrc_W=01 SHALL select LoadData_W, defined in REQ-020 to REQ-023.
REQ-019 ResultSrc_W=10 SHALL select PCPlus4_W; ResultSrc_W=11 SHALL select 64'h0.
REQ-020 The byte offset SHALL be ALUResult_W[2:0], with little-endian lane order (byte 0 is bits 7:0).
REQ-021 Load formatting by Funct3_W:
- 000 LB: byte at offset, sign-extended.
- 001 LH: halfword at offset[2:1], sign-extended.
- 010 LW: word at offset[2], sign-extended.
- 011 LD: ReadData_W unchanged.
- 100 LBU, 101 LHU, 110 LWU: as above, zero-extended.
- 111: treated as LD.
REQ-022 Misaligned low address bits SHALL be ignored: bit 0 for LH/LHU; bits 1:0 for LW/LWU; all three bits for LD.
REQ-023 Load formatting SHALL apply only when ResultSrc_W=01; for other selects, Funct3_W SHALL have no effect.
REQ-024 RegWrite_W SHALL equal RegWrite_W_q AND (Rd_W != 0), so x0 is never written.
REQ-025 Rd_W SHALL equal the registered Rd_M unchanged.

Reset
REQ-026 rst_n low SHALL immediately clear every W-stage register to 0, independent of clk.
REQ-027 While rst_n is low: Result_W=64'h0, RegWrite_W=0, Rd_W=0.
REQ-028 Deasserting rst_n SHALL take effect at the first rising clk edge with rst_n high.
REQ-029 Asserting rst_n mid-operation SHALL discard the in-flight instruction with no write.

Verification
REQ-030 Stimulus: ALUResult_M=AAAA_AAAA_AAAA_AAAA, ReadData_M=BBBB_BBBB_BBBB_BBBB, PCPlus4_M=0000_0000_0000_1004, Funct3_M=011, RegWrite_M=1, Rd_M=5.
- ResultSrc 00 -> one edge later, Result_W=AAAA_AAAA_AAAA_AAAA, RegWrite_W=1, Rd_W=5.
- ResultSrc 01 -> Result_W=BBBB_BBBB_BBBB_BBBB.
- ResultSrc 10 -> Result_W=0000_0000_0000_1004.
- ResultSrc 11 -> Result_W=0.
REQ-031 ReadData_M=8877_6655_4433_2211 and ResultSrc=01:
- LB, addr low 3 bits 111 -> FFFF_FFFF_FFFF_FF88.
- LBU, addr low 3 bits 111 -> 0000_0000_0000_0088.
- LH, addr low 3 bits 010 -> 0000_0000_0000_4433.
- LWU, addr low 3 bits 100 -> 0000_0000_8877_6655.
- LW, addr low 3 bits 100 -> FFFF_FFFF_8877_6655.
REQ-032 RegWrite_M=1 with Rd_M=0 -> RegWrite_W=0 one edge later.
REQ-033 Drive valid traffic, then pulse rst_n low between clock edges -> all outputs 0 immediately, and they stay 0 until the first edge after release.
REQ-034 Change the M inputs every cycle for 8 cycles -> each output reflects the previous cycle's M inputs, with no bubbles.
